// File: rtl/modmul_prod_2579.sv
// ---------------------------------------------------------------------------
// modmul_prod_2579
//
// Streaming operand-product stage feeding the q = 2579 Barrett reducer.
// It accepts pairs of 12-bit residues over valid/ready, multiplies them in
// an elastic two-stage pipeline (S1: operand register, S2: product
// register), and presents each 23-bit product with its frame marker. It also
// counts products handed off within the current frame.
//
// Optional feature (compile-time macro MODMUL_PROD_2579_RANGE_CHK_EN):
//   when defined, operands >= 2579 are flagged at S1 load. An erroring beat
//   carries out_err=1 and out_prod=0, keeps its last marker, and is counted.
//   When undefined, no comparator is built and out_err is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   stage can accept a pair (combinational)
//   in_a/in_b  operands, OW bits each
//   in_last    last pair of frame
//   out_valid  product valid
//   out_ready  downstream accepts product
//   out_prod   a*b truncated to PW bits
//   out_last   last product of frame
//   out_err    operand range violation (0 unless range check enabled)
//   prod_cnt   products handed off in the current frame (wraps silently)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module modmul_prod_2579 #(
  parameter int unsigned OW = 12,
  parameter int unsigned PW = 23,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [OW-1:0] in_a,
  input  logic [OW-1:0] in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_prod,
  output logic          out_last,
  output logic          out_err,
  output logic [CW-1:0] prod_cnt
);

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic          s1_valid_q, s1_valid_d;
  logic [OW-1:0] s1_a_q,     s1_a_d;
  logic [OW-1:0] s1_b_q,     s1_b_d;
  logic          s1_last_q,  s1_last_d;

  logic          s2_valid_q, s2_valid_d;
  logic [PW-1:0] s2_prod_q,  s2_prod_d;
  logic          s2_last_q,  s2_last_d;

  logic [CW-1:0] cnt_q,      cnt_d;

  // Handshake / advance strobes
  logic          in_hs;
  logic          out_hs;
  logic          s2_load;
  logic [PW-1:0] prod_w;

  // S2 may load when it is empty or its current beat leaves this cycle.
  // in_ready then depends on out_ready combinationally so that releasing
  // backpressure lets a new pair in on the same edge and the chain stays full.
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = s2_valid_q & out_ready;

  // Widening both operands to PW before multiplying keeps only the low PW
  // bits of the full OW x OW product, which is exactly the truncation wanted.
  assign prod_w = PW'(s1_a_q) * PW'(s1_b_q);

`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
  localparam int unsigned Q = 2579;

  logic s1_err_q, s1_err_d;
  logic s2_err_q, s2_err_d;
  logic in_err;

  assign in_err = (in_a >= OW'(Q)) | (in_b >= OW'(Q));
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a hold/default value first, so no
    // path through the block leaves a signal unassigned and no latch appears.
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_last_d  = s2_last_q;
    cnt_d      = cnt_q;
`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
    s1_err_d   = s1_err_q;
    s2_err_d   = s2_err_q;
`endif

    // S1: a new pair overrides the "moved on" case, since both can happen
    // in one cycle when S1 hands its beat to S2 and takes the next pair.
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_last_d  = in_last;
`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
      s1_err_d   = in_err;
`endif
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // S2: same priority scheme against the output handshake.
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_prod_d  = prod_w;
      s2_last_d  = s1_last_q;
`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
      s2_err_d   = s1_err_q;
      if (s1_err_q) begin
        s2_prod_d = '0;
      end
`endif
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end

    // Frame counter: the last beat closes the frame instead of being counted.
    if (out_hs) begin
      if (s2_last_q) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: data registers are reset along with the valid bits because
  // out_prod/out_last must read 0 out of reset, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_last_q  <= 1'b0;
      cnt_q      <= '0;
`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
      s1_err_q   <= 1'b0;
      s2_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, regardless of statement order.
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_last_q  <= s2_last_d;
      cnt_q      <= cnt_d;
`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
      s1_err_q   <= s1_err_d;
      s2_err_q   <= s2_err_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid = s2_valid_q;
  assign out_prod  = s2_prod_q;
  assign out_last  = s2_last_q;
  assign prod_cnt  = cnt_q;

`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
  assign out_err = s2_err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_modmul_prod_2579.sv
// ---------------------------------------------------------------------------
// tb_modmul_prod_2579
//
// Self-checking bench for modmul_prod_2579. A transaction-level model (a
// queue of expected beats computed with plain arithmetic, an occupancy-based
// in_ready rule and a frame counter) is compared against the DUT on every
// falling edge; directed scenarios add hand-computed literal expectations.
// Honors MODMUL_PROD_2579_RANGE_CHK_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_modmul_prod_2579;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_prod;
  logic        out_last;
  logic        out_err;
  logic [15:0] prod_cnt;

  modmul_prod_2579 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_last  (out_last),
    .out_err   (out_err),
    .prod_cnt  (prod_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct {
    int unsigned prod;
    bit          last;
    bit          err;
  } beat_t;

  beat_t       q[$];
  logic [15:0] cnt_m;
  bit          stall;

  function automatic beat_t model(input logic [11:0] a, input logic [11:0] b, input logic last);
    beat_t r;
    r.prod = (int'(a) * int'(b)) % (1 << 23);
    r.last = last;
    r.err  = 1'b0;
`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
    r.err = (a >= 12'd2579) || (b >= 12'd2579);
    if (r.err) r.prod = 0;
`endif
    return r;
  endfunction

  // Compare process: checks the state left by the previous rising edge, then
  // records the handshakes that the coming rising edge will complete.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt_m = '0;
      stall = 1'b0;
    end else begin
      beat_t h;
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      check("prod_cnt", prod_cnt, cnt_m);
      if (stall) check("valid_hold", out_valid, 1);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_beat", out_valid, 0);
        end else begin
          check("out_prod", out_prod, q[0].prod);
          check("out_last", out_last, q[0].last);
          check("out_err",  out_err,  q[0].err);
        end
      end
      stall = out_valid && !out_ready;
      if (out_valid && out_ready && q.size() > 0) begin
        h = q.pop_front();
        cnt_m = h.last ? 16'd0 : cnt_m + 16'd1;
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_last));
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (called at posedge + 1)
  // -------------------------------------------------------------------------
  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic last);
    bit hs;
    hs = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int k = 0; k < 50 && !hs; k++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!hs) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) break;
    end
    if (k >= 40) check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  logic [22:0] stream_exp [4];

  initial begin
    stream_exp[0] = 23'd1;
    stream_exp[1] = 23'd6;
    stream_exp[2] = 23'd2468000;
    stream_exp[3] = 23'd0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prod",  out_prod,  0);
    check("rst_out_last",  out_last,  0);
    check("rst_out_err",   out_err,   0);
    check("rst_prod_cnt",  prod_cnt,  0);
    check("rst_in_ready",  in_ready,  1);
    @(posedge clk);
    #1;

    // Single beat 2578*2578, last: two edges of latency
    send(12'd2578, 12'd2578, 1'b1);
    @(negedge clk);
    check("lat_s1_only", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_prod",  out_prod,  6646084);
    check("lat_last",  out_last,  1);
    @(posedge clk);
    @(negedge clk);
    check("lat_cnt_after", prod_cnt, 0);
    check("lat_empty",     out_valid, 0);
    @(posedge clk);
    #1;

    // Back-to-back stream of four pairs
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid = 1'b1;
        case (c)
          0: begin in_a = 12'd1;    in_b = 12'd1;    end
          1: begin in_a = 12'd2;    in_b = 12'd3;    end
          2: begin in_a = 12'd1234; in_b = 12'd2000; end
          default: begin in_a = 12'd0; in_b = 12'd2578; end
        endcase
        in_last = (c == 3);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clk);
      if (c < 4) check("stream_in_ready", in_ready, 1);
      if (c >= 2) begin
        check("stream_valid", out_valid, 1);
        check("stream_prod",  out_prod,  stream_exp[c-2]);
        check("stream_cnt",   prod_cnt,  c - 2);
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: out_ready low for five cycles during a stream
    out_ready = 1'b0;
    fork
      begin
        send(12'd10,   12'd20,   1'b0);
        send(12'd2578, 12'd1,    1'b0);
        send(12'd7,    12'd7,    1'b0);
        send(12'd100,  12'd25,   1'b0);
        send(12'd33,   12'd3,    1'b0);
        send(12'd1,    12'd2578, 1'b1);
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (c >= 2) begin
            check("bp_in_ready", in_ready,  0);
            check("bp_valid",    out_valid, 1);
            check("bp_frozen",   out_prod,  200);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Out-of-range operand
    send(12'd2579, 12'd5, 1'b1);
    begin
      int k;
      for (k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      check("range_valid", out_valid, 1);
`ifdef MODMUL_PROD_2579_RANGE_CHK_EN
      check("range_err",  out_err,  1);
      check("range_prod", out_prod, 0);
`else
      check("range_err",  out_err,  0);
      check("range_prod", out_prod, 12895);
`endif
    end
    @(posedge clk);
    #1;
    drain();

    // Reset while both stages are full
    send(12'd3, 12'd3, 1'b0);
    drain();
    check("pre_rst_cnt", prod_cnt, 1);
    out_ready = 1'b0;
    send(12'd4, 12'd4, 1'b0);
    send(12'd5, 12'd5, 1'b0);
    check("pre_rst_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_cnt",   prod_cnt,  0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // 65536 beats with last=0: the frame counter wraps back to 0
    for (int i = 0; i < 65536; i++) begin
      send(12'(i), 12'(i * 13), 1'b0);
    end
    drain();
    check("wrap_cnt", prod_cnt, 0);

    check("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
